// File: rtl/fetch_pc_queue.sv
// fetch_pc_queue: sequential PC generator feeding an N-deep in-order fetch
// queue. Requests go to an in-order, variable-latency imem; responses fill
// queue entries in order and the head entry is offered to decode. A redirect
// flushes the queue and arranges for stale in-flight responses to be dropped.
module fetch_pc_queue #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             req_valid,
  output logic [31:0]      req_addr,
  input  logic             req_ready,
  input  logic             resp_valid,
  input  logic [31:0]      resp_inst,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  input  logic             post_allowin,
  output logic [PTR_W:0]   queue_count
);

  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W+1:0] DISC_ONE   = (PTR_W+2)'(1);

  logic [31:0]      fetch_pc_reg;
  logic [PTR_W-1:0] head_ptr_reg;
  logic [PTR_W-1:0] alloc_ptr_reg;
  logic [PTR_W-1:0] fill_ptr_reg;
  logic [PTR_W:0]   alloc_count_reg;
  // Allocated entries whose instruction has not come back yet.
  logic [PTR_W:0]   pending_cnt_reg;
  // Responses still owed by imem for requests issued before a redirect.
  logic [PTR_W+1:0] discard_cnt_reg;
  logic [DEPTH-1:0] filled_reg;
  logic [DEPTH-1:0] filled_next;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];

  logic handshake;
  logic fill_en;
  logic drop_en;
  logic pop;

  // Request gating looks at the current count, so a pop in a full cycle does
  // not let a new request through until the following cycle.
  assign req_valid   = !reset && !redirect_valid && !fetch_stall &&
                       (alloc_count_reg < FULL_COUNT);
  assign req_addr    = fetch_pc_reg;
  assign handshake   = req_valid && req_ready;

  // Responses are consumed by the discard counter first; only once it is
  // empty do they belong to live queue entries.
  assign drop_en     = resp_valid && (discard_cnt_reg != '0);
  assign fill_en     = resp_valid && (discard_cnt_reg == '0) && !redirect_valid;

  assign out_valid   = !reset && !redirect_valid && (alloc_count_reg != '0) &&
                       filled_reg[head_ptr_reg];
  assign out_pc      = pc_mem[head_ptr_reg];
  assign out_inst    = inst_mem[head_ptr_reg];
  assign pop         = out_valid && post_allowin;
  assign queue_count = alloc_count_reg;

  // Per-entry filled flag: set by a matching fill, cleared on allocate or pop.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_filled
      assign filled_next[gi] =
        (fill_en && (fill_ptr_reg == PTR_W'(gi))) ? 1'b1 :
        ((handshake && (alloc_ptr_reg == PTR_W'(gi))) ||
         (pop && (head_ptr_reg == PTR_W'(gi))))     ? 1'b0 :
        filled_reg[gi];
    end
  endgenerate

  // Entry payload storage: PC captured at request, instruction at fill.
  always_ff @(posedge clk) begin
    if (handshake) pc_mem[alloc_ptr_reg] <= fetch_pc_reg;
    if (fill_en)   inst_mem[fill_ptr_reg] <= resp_inst;
  end

  // Control state: reset, then redirect flush, then normal queue operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      head_ptr_reg    <= '0;
      alloc_ptr_reg   <= '0;
      fill_ptr_reg    <= '0;
      alloc_count_reg <= '0;
      pending_cnt_reg <= '0;
      discard_cnt_reg <= '0;
      filled_reg      <= '0;
    end else if (redirect_valid) begin
      fetch_pc_reg    <= redirect_pc;
      head_ptr_reg    <= '0;
      alloc_ptr_reg   <= '0;
      fill_ptr_reg    <= '0;
      alloc_count_reg <= '0;
      pending_cnt_reg <= '0;
      filled_reg      <= '0;
      // Everything still in flight becomes discard; a response arriving now
      // retires one of those outstanding requests and is itself dropped.
      discard_cnt_reg <= discard_cnt_reg + (PTR_W+2)'(pending_cnt_reg) -
                         (PTR_W+2)'(resp_valid);
    end else begin
      if (handshake) begin
        fetch_pc_reg  <= fetch_pc_reg + 32'd4;
        alloc_ptr_reg <= alloc_ptr_reg + PTR_ONE;
      end
      if (fill_en) fill_ptr_reg    <= fill_ptr_reg + PTR_ONE;
      if (drop_en) discard_cnt_reg <= discard_cnt_reg - DISC_ONE;
      if (pop)     head_ptr_reg    <= head_ptr_reg + PTR_ONE;
      alloc_count_reg <= alloc_count_reg + (PTR_W+1)'(handshake) - (PTR_W+1)'(pop);
      pending_cnt_reg <= pending_cnt_reg + (PTR_W+1)'(handshake) - (PTR_W+1)'(fill_en);
      filled_reg      <= filled_next;
    end
  end

  // An imem response must always correspond to an issued-but-unreturned request.
  a_resp_has_owner: assert property (@(posedge clk) disable iff (reset)
    resp_valid |-> ((pending_cnt_reg != '0) || (discard_cnt_reg != '0)));

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Testbench for fetch_pc_queue: in-order imem model with configurable latency,
// directed stimulus, and a scoreboard monitor that checks every accepted
// decode transfer against hand-listed expected PCs.
module tb_fetch_pc_queue;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        post_allowin;
  logic [2:0]  queue_count;

  fetch_pc_queue #(.RESET_PC(32'hBFC0_0000), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .fetch_stall(fetch_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_inst(resp_inst),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .post_allowin(post_allowin), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          lat   = 1;
  logic [31:0] exp_q [$];
  logic [31:0] mem_inst_q [$];
  int          mem_due_q [$];
  logic [31:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %08h required %08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0b required %0b", name, act, exp);
    end
  endtask

  // imem model: responds in order, lat cycles after each accepted request.
  initial begin
    resp_valid = 1'b0;
    resp_inst  = '0;
    forever begin
      @(posedge clk);
      #3;
      resp_valid = 1'b0;
      if (!reset && mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
        resp_valid = 1'b1;
        resp_inst  = mem_inst_q.pop_front();
        void'(mem_due_q.pop_front());
      end
      #5;
      if (reset) begin
        mem_inst_q.delete();
        mem_due_q.delete();
      end else if (req_valid && req_ready) begin
        mem_inst_q.push_back(inst_of(req_addr));
        mem_due_q.push_back(cyc + lat);
      end
    end
  end

  // Scoreboard monitor: every transfer into decode must match the next expected PC.
  initial begin
    forever begin
      @(posedge clk);
      #8;
      if (!reset && out_valid && post_allowin && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: actual pc %08h required no transfer", out_pc);
        end else begin
          mon_exp = exp_q.pop_front();
          $display("decode pc=%08h inst=%08h", out_pc, out_inst);
          chk("out_pc", out_pc, mon_exp);
          chk("out_inst", out_inst, inst_of(mon_exp));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One cycle: drive inputs early in the cycle, return mid-cycle for checks.
  task automatic step(input logic st, input logic al, input logic rd, input logic [31:0] rpc);
    tick();
    reset          = 1'b0;
    fetch_stall    = st;
    post_allowin   = al;
    redirect_valid = rd;
    redirect_pc    = rpc;
    #2;
  endtask

  task automatic do_reset(input int l);
    tick();
    reset = 1'b1; fetch_stall = 1'b0; post_allowin = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; lat = l;
    tick();
    #2;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_req_valid", req_valid, 1'b0);
    chk("rst_queue_count", 32'(queue_count), 32'd0);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    do begin
      tick();
      reset = 1'b0; fetch_stall = 1'b1; post_allowin = 1'b1; redirect_valid = 1'b0;
      k++;
    end while ((exp_q.size() != 0 || mem_due_q.size() != 0) && k < 60);
    chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_count"}, 32'(queue_count), 32'd0);
  endtask

  initial begin
    reset = 1'b1; fetch_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    post_allowin = 1'b0; req_ready = 1'b1;

    // Streaming with 1-cycle imem: one request per cycle, first output at cycle 2.
    do_reset(1);
    for (int k = 0; k < 8; k++) exp_q.push_back(RST_PC + 32'(4 * k));
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk1("t1_req_valid", req_valid, 1'b1);
      chk("t1_req_addr", req_addr, RST_PC + 32'(4 * k));
      if (k < 2) chk1("t1_out_valid_early", out_valid, 1'b0);
      if (k == 2) chk("t1_first_pc", out_pc, RST_PC);
      if (k >= 2) chk1("t1_no_bubble", out_valid, 1'b1);
    end
    drain("t1");

    // Decode blocked: exactly four requests, then drain and resume at +0x10.
    do_reset(1);
    for (int k = 0; k < 5; k++) exp_q.push_back(RST_PC + 32'(4 * k));
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (k < 4) begin
        chk1("t2_req_valid", req_valid, 1'b1);
        chk("t2_req_addr", req_addr, RST_PC + 32'(4 * k));
      end else begin
        chk1("t2_full_req_valid", req_valid, 1'b0);
      end
    end
    chk("t2_queue_count", 32'(queue_count), 32'd4);
    chk1("t2_out_valid", out_valid, 1'b1);
    chk("t2_head_pc", out_pc, RST_PC);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk1("t2_pop_full_req_valid", req_valid, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk1("t2_resume_req_valid", req_valid, 1'b1);
    chk("t2_resume_addr", req_addr, RST_PC + 32'h10);
    drain("t2");

    // 3-cycle imem, redirect with two responses outstanding.
    do_reset(3);
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h8000_0004);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t3_req0", req_addr, RST_PC);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t3_req1", req_addr, RST_PC + 32'h4);
    step(1'b1, 1'b1, 1'b1, 32'h8000_0000);
    chk1("t3_redir_req_valid", req_valid, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk1("t3_new_req_valid", req_valid, 1'b1);
    chk("t3_new_req_addr", req_addr, 32'h8000_0000);
    chk1("t3_c3_out_valid", out_valid, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t3_new_req_addr2", req_addr, 32'h8000_0004);
    chk1("t3_c4_out_valid", out_valid, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk1("t3_c5_out_valid", out_valid, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk1("t3_c6_out_valid", out_valid, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk1("t3_c7_out_valid", out_valid, 1'b1);
    chk("t3_first_pc", out_pc, 32'h8000_0000);
    chk("t3_first_inst", out_inst, inst_of(32'h8000_0000));
    drain("t3");

    // Redirect in the same cycle as a response and a would-be pop.
    do_reset(1);
    exp_q.push_back(RST_PC);
    exp_q.push_back(RST_PC + 32'h4);
    exp_q.push_back(32'h9000_0000);
    exp_q.push_back(32'h9000_0004);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("t4_req_addr", req_addr, RST_PC + 32'(4 * k));
    end
    step(1'b0, 1'b1, 1'b1, 32'h9000_0000);
    chk1("t4_redir_out_valid", out_valid, 1'b0);
    chk1("t4_redir_req_valid", req_valid, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t4_new_req_addr", req_addr, 32'h9000_0000);
    chk1("t4_c5_out_valid", out_valid, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t4_new_req_addr2", req_addr, 32'h9000_0004);
    chk1("t4_c6_out_valid", out_valid, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk1("t4_c7_out_valid", out_valid, 1'b1);
    chk("t4_first_pc", out_pc, 32'h9000_0000);
    drain("t4");

    // fetch_stall for five cycles with a partly filled queue.
    do_reset(1);
    exp_q.push_back(RST_PC);
    exp_q.push_back(RST_PC + 32'h4);
    exp_q.push_back(RST_PC + 32'h8);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    for (int k = 2; k < 7; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk1("t5_stall_req_valid", req_valid, 1'b0);
      chk("t5_stall_fetch_pc", req_addr, RST_PC + 32'h8);
      if (k == 2) chk("t5_drain_pc0", out_pc, RST_PC);
      if (k == 3) chk("t5_drain_pc1", out_pc, RST_PC + 32'h4);
      chk1("t5_out_valid", out_valid, (k < 4) ? 1'b1 : 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk1("t5_resume_req_valid", req_valid, 1'b1);
    chk("t5_resume_addr", req_addr, RST_PC + 32'h8);
    drain("t5");

    // Reset with a full queue.
    do_reset(1);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t6_full_count", 32'(queue_count), 32'd4);
    chk1("t6_full_out_valid", out_valid, 1'b1);
    tick();
    reset = 1'b1; post_allowin = 1'b0; fetch_stall = 1'b0;
    #2;
    chk1("t6_rst_req_valid", req_valid, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk1("t6_post_out_valid", out_valid, 1'b0);
    chk("t6_post_count", 32'(queue_count), 32'd0);
    chk("t6_post_req_addr", req_addr, RST_PC);
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
